ram_arbiter_ctrl: RTL and testbench
===================================

Name: ram_arbiter_ctrl

Overview:
- Owns the 32x8 single-write/single-read synchronous RAM. The RAM has a registered read: q is updated every clock from raddr, and we writes d at posedge.
- After reset, or on request, the block fills the RAM with a deterministic pattern. This means synthesis does not depend on the RAM's own initial-block contents.
- It then shares the RAM between two requesters (port 0 and port 1) using round-robin arbitration, with one access per cycle.
- It sits between the requesting logic and the RAM instance.

Parameters:
- DW, 8, data width.
- AW, 5, address width.
- DEPTH, 32, number of words filled during init; must be ≤ 2**AW.
- INIT_MODE, 1, fill pattern: 0 = all zero, 1 = mem[i] = i[DW-1:0].

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- init_start  in  1  one-cycle pulse; restarts the fill sequence (honoured only in RUN).
- init_busy  out  1  high while filling.
- req0_valid  in  1  port 0 request.
- req0_we  in  1  port 0: 1 = write, 0 = read.
- req0_addr  in  AW  port 0 address.
- req0_wdata  in  DW  port 0 write data.
- req0_ready  out  1  port 0 grant; the access is taken this cycle.
- rsp0_valid  out  1  port 0 read data valid.
- rsp0_rdata  out  DW  port 0 read data.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: identical set for port 1.
- ram_we  out  1  RAM write enable.
- ram_waddr  out  AW  RAM write address.
- ram_d  out  DW  RAM write data.
- ram_raddr  out  AW  RAM read address.
- ram_q  in  DW  RAM registered read data.

Behaviour:
- Reset (rst_n low, asynchronous): state=INIT, init_cnt=0, last_grant=1 (so port 0 wins first), rsp0_valid=rsp1_valid=0, init_busy=1. ram_we, req0_ready, req1_ready and all RAM addresses are 0.
- FSM states: INIT, RUN.
- INIT state:
  - Each cycle: ram_we=1, ram_waddr=init_cnt, ram_d = 0 (INIT_MODE=0) or init_cnt zero-extended/truncated to DW (INIT_MODE=1). init_cnt then increments.
  - When init_cnt==DEPTH-1 is written, go to RUN next cycle. INIT lasts exactly DEPTH cycles after reset release.
  - Both readies stay 0; requests are not consumed. init_start is ignored.
- RUN state:
  - init_busy=0.
  - init_start=1: grant nothing this cycle, clear init_cnt, enter INIT next cycle. A read granted in the previous cycle still delivers its response.
  - Arbitration (combinational, one grant per cycle):
    - Only one valid: grant it.
    - Both valid: grant the port ≠ last_grant.
    - last_grant updates on every grant.
    - A port holding valid high is granted within 2 cycles (no starvation).
  - Granted write: ram_we=1, ram_waddr=addr, ram_d=wdata, all in the same cycle.
  - Granted read: ram_raddr=addr. rsp_valid of that port is registered high for exactly the next cycle, with rsp_rdata = ram_q (pass-through) during that cycle. Read latency is 1 cycle.
  - rsp_rdata outside rsp_valid: don't-care.
  - No grant: ram_we=0; ram_raddr holds 0.
- Read-after-write:
  - Write granted in cycle N, read of the same address granted in N+1: returns the new data.
  - Write and read in the same cycle cannot occur (single grant).
- Back-to-back reads from alternating ports: one response per cycle, each steered to the port granted in the previous cycle.
- Reset mid-INIT or mid-RUN: immediate return to reset values; the fill restarts from address 0 after release.
- Address width: addresses pass through unmodified. init_cnt is AW+1 bits wide so DEPTH=2**AW terminates correctly.

Decomposition:
- Shared package ram_ctrl_pkg:
  - state encoding constants ST_INIT and ST_RUN.
  - INIT_MODE codes INIT_ZERO=0 and INIT_ADDR=1.
  - Default DW/AW/DEPTH constants.
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter (valid[1:0], last_grant -> grant[1:0]). Everything else stays in ram_arbiter_ctrl.
- The RAM itself is instantiated by the parent, not inside this block.

Test Plan:
- Release reset, no requests, INIT_MODE=1 -> init_busy high for exactly 32 cycles. ram_we=1 with waddr/d = 0..31 in order, then init_busy=0 and ram_we=0.
- After init, port 0 reads addr 5 -> req0_ready=1 that cycle; next cycle rsp0_valid=1, rsp0_rdata=8'h05, rsp1_valid=0.
- Port 1 writes 8'hA5 to addr 3, then reads addr 3 the next cycle -> ram_we=1/waddr=3/d=A5, then rsp1_rdata=8'hA5 one cycle after the read grant.
- Both ports hold reads (addr 1, addr 2) for 4 cycles -> grants alternate 0,1,0,1. Responses 8'h01/8'h02 arrive on the matching port one cycle after each grant.
- Requests valid during INIT -> readies stay 0 for all 32 fill cycles; first grant goes to port 0 in the first RUN cycle.
- init_start pulse in RUN, then rst_n pulled low for 1 cycle at init_cnt=10 -> INIT re-entered. After the reset, the fill restarts at waddr 0 and runs a full 32 cycles.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM fill/arbitration controller: FSM encoding,
// fill-pattern codes and default geometry.
package ram_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int INIT_ZERO = 0;
  localparam int INIT_ADDR = 1;

  localparam int DEF_DW    = 8;
  localparam int DEF_AW    = 5;
  localparam int DEF_DEPTH = 32;

endpackage

// File: rtl/ram_arbiter_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, on contention
// the port that did not win last time is granted.
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ram_arbiter_ctrl.sv
// Fills the shared 32x8 RAM with a deterministic pattern after reset or on
// request, then time-shares it between two requesters one access per cycle.
module ram_arbiter_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int AW        = DEF_AW,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int INIT_MODE = INIT_ADDR
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init_start,
  output logic          init_busy,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_d,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_q
);

  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  state_e      state_q, state_d;
  logic [AW:0] init_cnt_q, init_cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic [1:0]  grant;
  logic [DW-1:0] fill_val;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign fill_val   = DW'(init_cnt_q);
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = ram_q;
  assign rsp1_rdata = ram_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      last_grant_q <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      last_grant_q <= last_grant_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    last_grant_d = last_grant_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    init_busy    = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    ram_we       = 1'b0;
    ram_waddr    = '0;
    ram_d        = '0;
    ram_raddr    = '0;
    unique case (state_q)
      ST_INIT: begin
        init_busy  = 1'b1;
        // Keep the RAM untouched while reset is still asserted.
        ram_we     = rst_n;
        ram_waddr  = init_cnt_q[AW-1:0];
        ram_d      = (INIT_MODE == INIT_ADDR) ? fill_val : '0;
        init_cnt_d = init_cnt_q + CNT_ONE;
        if (init_cnt_q == LAST_IDX) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (init_start) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end else if (grant[0]) begin
          req0_ready   = 1'b1;
          last_grant_d = 1'b0;
          if (req0_we) begin
            ram_we    = 1'b1;
            ram_waddr = req0_addr;
            ram_d     = req0_wdata;
          end else begin
            ram_raddr    = req0_addr;
            rsp0_valid_d = 1'b1;
          end
        end else if (grant[1]) begin
          req1_ready   = 1'b1;
          last_grant_d = 1'b1;
          if (req1_we) begin
            ram_we    = 1'b1;
            ram_waddr = req1_addr;
            ram_d     = req1_wdata;
          end else begin
            ram_raddr    = req1_addr;
            rsp1_valid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter_ctrl.sv
// Directed bench for ram_arbiter_ctrl with a behavioural registered-read RAM
// attached to the RAM-side ports.
module tb_ram_arbiter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       initStart;
  logic       initBusy;
  logic       req0Valid, req0We, req0Ready, rsp0Valid;
  logic [4:0] req0Addr;
  logic [7:0] req0Wdata, rsp0Rdata;
  logic       req1Valid, req1We, req1Ready, rsp1Valid;
  logic [4:0] req1Addr;
  logic [7:0] req1Wdata, rsp1Rdata;
  logic       ramWe;
  logic [4:0] ramWaddr, ramRaddr;
  logic [7:0] ramD, ramQ;
  logic [7:0] mem [32];

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  // Registered-read RAM model sitting behind the controller.
  always_ff @(posedge clk) begin
    if (ramWe) mem[ramWaddr] <= ramD;
    ramQ <= mem[ramRaddr];
  end

  ram_arbiter_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_start (initStart),
    .init_busy  (initBusy),
    .req0_valid (req0Valid),
    .req0_we    (req0We),
    .req0_addr  (req0Addr),
    .req0_wdata (req0Wdata),
    .req0_ready (req0Ready),
    .rsp0_valid (rsp0Valid),
    .rsp0_rdata (rsp0Rdata),
    .req1_valid (req1Valid),
    .req1_we    (req1We),
    .req1_addr  (req1Addr),
    .req1_wdata (req1Wdata),
    .req1_ready (req1Ready),
    .rsp1_valid (rsp1Valid),
    .rsp1_rdata (rsp1Rdata),
    .ram_we     (ramWe),
    .ram_waddr  (ramWaddr),
    .ram_d      (ramD),
    .ram_raddr  (ramRaddr),
    .ram_q      (ramQ)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive both request ports; called just after a rising edge.
  task automatic applyStimulus(input logic v0, input logic we0, input logic [4:0] a0, input logic [7:0] d0,
                               input logic v1, input logic we1, input logic [4:0] a1, input logic [7:0] d1);
    req0Valid = v0; req0We = we0; req0Addr = a0; req0Wdata = d0;
    req1Valid = v1; req1We = we1; req1Addr = a1; req1Wdata = d1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkFill(input string tag, input int idx);
    checkOutput({tag, "_busy"}, 32'(initBusy), 32'd1);
    checkOutput({tag, "_we"}, 32'(ramWe), 32'd1);
    checkOutput({tag, "_waddr"}, 32'(ramWaddr), 32'(idx));
    checkOutput({tag, "_d"}, 32'(ramD), 32'(idx));
    checkOutput({tag, "_rdy"}, {30'd0, req1Ready, req0Ready}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    initStart = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("rst_busy", 32'(initBusy), 32'd1);
    checkOutput("rst_we", 32'(ramWe), 32'd0);
    checkOutput("rst_rdy", {30'd0, req1Ready, req0Ready}, 32'd0);
    checkOutput("rst_rsp", {30'd0, rsp1Valid, rsp0Valid}, 32'd0);
    checkOutput("rst_addr", {22'd0, ramWaddr, ramRaddr}, 32'd0);

    // Fill sequence after reset release: 32 cycles writing mem[i] = i.
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      checkFill("fill", i);
      tick();
    end
    checkOutput("run_busy", 32'(initBusy), 32'd0);
    checkOutput("run_we", 32'(ramWe), 32'd0);

    // Port 0 reads address 5.
    applyStimulus(1, 0, 5'd5, 0, 0, 0, 0, 0);
    checkOutput("rd5_rdy0", 32'(req0Ready), 32'd1);
    checkOutput("rd5_raddr", 32'(ramRaddr), 32'd5);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rd5_rsp0", 32'(rsp0Valid), 32'd1);
    checkOutput("rd5_data", 32'(rsp0Rdata), 32'h05);
    checkOutput("rd5_rsp1", 32'(rsp1Valid), 32'd0);
    tick();
    checkOutput("rd5_rsp0_drop", 32'(rsp0Valid), 32'd0);

    // Port 1 writes A5 to address 3, then reads it back.
    applyStimulus(0, 0, 0, 0, 1, 1, 5'd3, 8'hA5);
    checkOutput("wr3_rdy1", 32'(req1Ready), 32'd1);
    checkOutput("wr3_we", 32'(ramWe), 32'd1);
    checkOutput("wr3_waddr", 32'(ramWaddr), 32'd3);
    checkOutput("wr3_d", 32'(ramD), 32'hA5);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0, 5'd3, 0);
    checkOutput("rd3_rdy1", 32'(req1Ready), 32'd1);
    checkOutput("rd3_we", 32'(ramWe), 32'd0);
    checkOutput("rd3_rsp1_none", 32'(rsp1Valid), 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rd3_rsp1", 32'(rsp1Valid), 32'd1);
    checkOutput("rd3_data", 32'(rsp1Rdata), 32'hA5);
    checkOutput("rd3_rsp0", 32'(rsp0Valid), 32'd0);
    tick();

    // Both ports hold reads; last winner was port 1 so port 0 goes first.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 5'd1, 0, 1, 0, 5'd2, 0);
      checkOutput($sformatf("alt%0d_rdy", k), {30'd0, req1Ready, req0Ready},
                  (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0) begin
        checkOutput($sformatf("alt%0d_rsp", k), {30'd0, rsp1Valid, rsp0Valid},
                    (k % 2 == 0) ? 32'd2 : 32'd1);
        checkOutput($sformatf("alt%0d_data", k), 32'((k % 2 == 0) ? rsp1Rdata : rsp0Rdata),
                    (k % 2 == 0) ? 32'h02 : 32'h01);
      end
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("alt_last_rsp", {30'd0, rsp1Valid, rsp0Valid}, 32'd2);
    checkOutput("alt_last_data", 32'(rsp1Rdata), 32'h02);
    tick();

    // init_start with requests pending: nothing granted, fill restarts.
    initStart = 1'b1;
    applyStimulus(1, 0, 5'd7, 0, 1, 0, 5'd8, 0);
    checkOutput("istart_rdy", {30'd0, req1Ready, req0Ready}, 32'd0);
    checkOutput("istart_we", 32'(ramWe), 32'd0);
    tick();
    initStart = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      checkFill("refill", i);
      tick();
    end
    checkOutput("refill10_waddr", 32'(ramWaddr), 32'd10);

    // Reset at init_cnt = 10 restarts the fill from address 0.
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(initBusy), 32'd1);
    checkOutput("midrst_we", 32'(ramWe), 32'd0);
    checkOutput("midrst_waddr", 32'(ramWaddr), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      checkFill("postrst", i);
      tick();
    end
    checkOutput("postrst_busy", 32'(initBusy), 32'd0);
    checkOutput("postrst_first_grant", {30'd0, req1Ready, req0Ready}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("postrst_rsp0", 32'(rsp0Valid), 32'd1);
    checkOutput("postrst_data", 32'(rsp0Rdata), 32'h07);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
